// File: rtl/step_ctrl.sv
// step_ctrl: execution-rate controller for the multicycle MIPS core.
// Emits a one-clock cpu_en pulse that advances the core, either free-running
// at a switch-selected rate or one step per debounced button press.
// Also counts issued pulses for the display block.

module step_ctrl #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DIV0      = 100_000_000,
  parameter int DIV1      = 25_000_000,
  parameter int DIV2      = 1_000_000,
  parameter int DIV3      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_step,
  input  logic        sw_run,
  input  logic [1:0]  sw_speed,
  output logic        cpu_en,
  output logic [15:0] step_count,
  output logic [1:0]  mode
);

  localparam logic [1:0] PAUSE = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           btn_s1, btn_s2;
  logic           run_s1, run_s2;
  logic [1:0]     spd_s1, spd_s2;

  logic [DBW-1:0] db_cnt;
  logic           btn_db;
  logic           btn_db_d;
  logic           btn_rise;

  logic [1:0]     state, state_nxt;
  logic [31:0]    cnt, cnt_nxt;
  logic [31:0]    period_m1;
  logic           en_nxt;

  // Two-flop synchronizers bring the asynchronous button and switches into clk.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      spd_s1 <= 2'd0;
      spd_s2 <= 2'd0;
    end else begin
      btn_s1 <= btn_step;
      btn_s2 <= btn_s1;
      run_s1 <= sw_run;
      run_s2 <= run_s1;
      spd_s1 <= sw_speed;
      spd_s2 <= spd_s1;
    end
  end

  // Debounce: accept a new button level only after it has disagreed with the
  // current level for DB_CYCLES consecutive clocks; any agreement restarts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign btn_rise = btn_db & ~btn_db_d;

  // Run period minus one, selected live so a speed change applies at once.
  always_comb begin
    period_m1 = 32'(DIV0 - 1);
    case (spd_s2)
      2'd0:    period_m1 = 32'(DIV0 - 1);
      2'd1:    period_m1 = 32'(DIV1 - 1);
      2'd2:    period_m1 = 32'(DIV2 - 1);
      default: period_m1 = 32'(DIV3 - 1);
    endcase
  end

  // Mode FSM and rate counter; a step press beats the run switch in PAUSE,
  // and the >= compare lets a shortened period fire without waiting for wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    en_nxt    = 1'b0;
    case (state)
      PAUSE: begin
        cnt_nxt = '0;
        if (btn_rise) begin
          en_nxt    = 1'b1;
          state_nxt = HOLD;
        end else if (run_s2) begin
          state_nxt = RUN;
        end
      end
      HOLD: begin
        cnt_nxt = '0;
        if (!btn_db) begin
          state_nxt = PAUSE;
        end
      end
      RUN: begin
        if (!run_s2) begin
          state_nxt = PAUSE;
          cnt_nxt   = '0;
        end else if (cnt >= period_m1) begin
          en_nxt  = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      default: begin
        state_nxt = PAUSE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered pulse; step_count tracks every pulse issued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= PAUSE;
      cnt        <= '0;
      cpu_en     <= 1'b0;
      step_count <= 16'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cpu_en <= en_nxt;
      if (en_nxt) begin
        step_count <= step_count + 16'd1;
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed self-checking bench for step_ctrl with small
// debounce and rate constants so every scenario runs in a few clocks.

module tb_step_ctrl;

  logic        clk;
  logic        reset_n;
  logic        btn_step;
  logic        sw_run;
  logic [1:0]  sw_speed;
  logic        cpu_en;
  logic [15:0] step_count;
  logic [1:0]  mode;

  int errors;
  int checks;
  int total;
  int pulses;
  int zeros;
  int n;
  int guard;

  step_ctrl #(
    .DB_CYCLES(4),
    .DIV0(8),
    .DIV1(4),
    .DIV2(2),
    .DIV3(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_step(btn_step),
    .sw_run(sw_run),
    .sw_speed(sw_speed),
    .cpu_en(cpu_en),
    .step_count(step_count),
    .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clocks, sampling on the falling edge and tallying pulses.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      if (cpu_en === 1'b1) begin
        pulses++;
        total++;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Clocks until mode equals m, or -1 if the limit expires.
  task automatic waitMode(input logic [1:0] m, input int limit, output int cnt_out);
    int i;
    i = 0;
    cnt_out = -1;
    while (cnt_out < 0 && i < limit) begin
      i++;
      applyStimulus(1);
      if (mode === m) cnt_out = i;
    end
  endtask

  // Clocks until the next cpu_en pulse, or -1 if the limit expires.
  task automatic waitPulse(input int limit, output int cnt_out);
    int i;
    i = 0;
    cnt_out = -1;
    while (cnt_out < 0 && i < limit) begin
      i++;
      applyStimulus(1);
      if (cpu_en === 1'b1) cnt_out = i;
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    total    = 0;
    pulses   = 0;
    zeros    = 0;
    reset_n  = 1'b0;
    btn_step = 1'b0;
    sw_run   = 1'b1;
    sw_speed = 2'd0;

    // Reset held with the run switch on
    applyStimulus(3);
    total  = 0;
    pulses = 0;
    checkOutput("rst_en", int'(cpu_en), 0);
    checkOutput("rst_count", int'(step_count), 0);
    checkOutput("rst_mode", int'(mode), 0);
    reset_n = 1'b1;
    waitMode(2'd1, 10, n);
    checkOutput("run_latency", n, 3);
    waitPulse(12, n);
    checkOutput("first_pulse", n, 8);
    checkOutput("count_first", int'(step_count), 1);
    sw_run = 1'b0;
    waitMode(2'd0, 10, n);
    checkOutput("pause_latency", n, 3);
    checkOutput("count_after_pause", int'(step_count), 1);

    // Bouncy press yields exactly one step
    pulses = 0;
    btn_step = 1'b1; applyStimulus(2);
    btn_step = 1'b0; applyStimulus(2);
    btn_step = 1'b1; applyStimulus(2);
    btn_step = 1'b0; applyStimulus(2);
    btn_step = 1'b1; applyStimulus(10);
    checkOutput("bounce_pulses", pulses, 1);
    checkOutput("bounce_count", int'(step_count), 2);
    checkOutput("bounce_mode", int'(mode), 2);
    btn_step = 1'b0;
    applyStimulus(8);
    checkOutput("release_mode", int'(mode), 0);
    checkOutput("release_pulses", pulses, 1);

    // Free-run at speed 0, then shorten the period mid-count
    sw_run = 1'b1;
    waitMode(2'd1, 10, n);
    checkOutput("rate_enter", n, 3);
    pulses = 0;
    applyStimulus(40);
    checkOutput("rate_pulses", pulses, 5);
    checkOutput("rate_last", int'(cpu_en), 1);
    applyStimulus(3);
    sw_speed = 2'd2;
    waitPulse(10, n);
    checkOutput("speed_change_gap", n, 3);
    waitPulse(10, n);
    checkOutput("fast_gap1", n, 2);
    waitPulse(10, n);
    checkOutput("fast_gap2", n, 2);
    checkOutput("rate_count", int'(step_count), 10);
    sw_run = 1'b0;
    waitMode(2'd0, 10, n);
    checkOutput("rate_pause", n, 3);
    checkOutput("rate_pause_count", int'(step_count), total % 65536);

    // Button rise and run switch land on the same clock in PAUSE
    pulses = 0;
    btn_step = 1'b1;
    applyStimulus(4);
    sw_run = 1'b1;
    applyStimulus(6);
    checkOutput("sim_pulses", pulses, 1);
    checkOutput("sim_mode", int'(mode), 2);
    applyStimulus(5);
    checkOutput("hold_mode", int'(mode), 2);
    checkOutput("hold_pulses", pulses, 1);
    btn_step = 1'b0;
    waitMode(2'd0, 12, n);
    checkOutput("hold_release", n, 7);
    applyStimulus(1);
    checkOutput("resume_run", int'(mode), 1);
    sw_run = 1'b0;
    waitMode(2'd0, 10, n);
    checkOutput("sim_pause_count", int'(step_count), total % 65536);

    // Button ignored in RUN, then reset lands mid-count
    sw_speed = 2'd0;
    applyStimulus(4);
    sw_run = 1'b1;
    waitMode(2'd1, 10, n);
    checkOutput("run2_enter", n, 3);
    pulses = 0;
    btn_step = 1'b1;
    applyStimulus(14);
    checkOutput("run_btn_pulses", pulses, 1);
    checkOutput("run_btn_mode", int'(mode), 1);
    reset_n  = 1'b0;
    sw_run   = 1'b0;
    btn_step = 1'b0;
    applyStimulus(1);
    checkOutput("midrst_en", int'(cpu_en), 0);
    checkOutput("midrst_mode", int'(mode), 0);
    checkOutput("midrst_count", int'(step_count), 0);
    total  = 0;
    pulses = 0;
    applyStimulus(2);
    reset_n = 1'b1;
    applyStimulus(4);
    checkOutput("post_rst_mode", int'(mode), 0);
    checkOutput("post_rst_count", int'(step_count), 0);
    checkOutput("post_rst_pulses", pulses, 0);

    // Speed 3: continuous enable and step_count wrap
    sw_speed = 2'd3;
    sw_run   = 1'b1;
    waitMode(2'd1, 10, n);
    checkOutput("fast_enter", n, 3);
    zeros = 0;
    guard = 0;
    while (total < 65535 && guard < 70000) begin
      guard++;
      applyStimulus(1);
      if (cpu_en !== 1'b1) zeros++;
    end
    checkOutput("wrap_pre", int'(step_count), 65535);
    checkOutput("continuous", zeros, 0);
    applyStimulus(1);
    checkOutput("wrap", int'(step_count), 0);
    checkOutput("wrap_en", int'(cpu_en), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
